if_stage: RTL and testbench



---
 rtl/if_stage.sv | 129 ++++++++++++
 tb/tb_if_stage.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: fetch PC, single-outstanding imem reads, fetch buffer
// Optional IF_BUF_BYPASS_EN: an ack into an empty buffer is presented to decode in the same cycle.
module if_stage #(
   parameter int unsigned       ADDR_W     = 32,
   parameter int unsigned       INSTR_W    = 32,
   parameter logic [ADDR_W-1:0] RESET_PC   = '0,
   parameter int unsigned       PC_STEP    = 4,
   parameter int unsigned       FIFO_DEPTH = 2
) (
   input  logic               clk,
   input  logic               aresetn,
   input  logic               i_stall,
   input  logic               i_redirect,
   input  logic [ADDR_W-1:0]  i_redirect_pc,
   output logic               o_imem_req,
   output logic [ADDR_W-1:0]  o_imem_addr,
   input  logic               i_imem_ack,
   input  logic [INSTR_W-1:0] i_imem_data,
   output logic [ADDR_W-1:0]  o_pc,
   output logic [INSTR_W-1:0] o_instr,
   output logic               o_valid
);

   localparam int unsigned       PTR_W      = $clog2(FIFO_DEPTH);
   localparam int unsigned       CNT_W      = PTR_W + 1;
   localparam int unsigned       STEP_SH    = $clog2(PC_STEP);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << STEP_SH) - ADDR_W'(1));
   localparam logic [ADDR_W-1:0] STEP_C     = ADDR_W'(PC_STEP);
   localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} state_t;

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   fetch_pc, fetch_pc_nxt;
   logic [ADDR_W-1:0]   buf_pc    [FIFO_DEPTH];
   logic [INSTR_W-1:0]  buf_instr [FIFO_DEPTH];
   logic [PTR_W-1:0]    rd_ptr, wr_ptr;
   logic [CNT_W-1:0]    count, count_after_pop, count_nxt;
   logic                fifo_nonempty, take_ack, bypass_take, push, pop;

   assign fifo_nonempty = (count != '0);
   assign take_ack      = (state == S_REQ) && i_imem_ack && !i_redirect;

`ifdef IF_BUF_BYPASS_EN
   logic bypass_hit;
   assign bypass_hit  = take_ack && !fifo_nonempty;
   assign bypass_take = bypass_hit && !i_stall;
   assign o_valid     = fifo_nonempty || bypass_hit;
   assign o_pc        = fifo_nonempty ? buf_pc[rd_ptr]    : (bypass_hit ? fetch_pc    : '0);
   assign o_instr     = fifo_nonempty ? buf_instr[rd_ptr] : (bypass_hit ? i_imem_data : '0);
`else
   assign bypass_take = 1'b0;
   assign o_valid     = fifo_nonempty;
   assign o_pc        = fifo_nonempty ? buf_pc[rd_ptr]    : '0;
   assign o_instr     = fifo_nonempty ? buf_instr[rd_ptr] : '0;
`endif

   // a word consumed straight from the bypass never occupies a buffer slot
   assign push            = take_ack && !bypass_take;
   assign pop             = fifo_nonempty && !i_stall;
   assign count_after_pop = count - CNT_W'(pop);
   assign count_nxt       = count_after_pop + CNT_W'(push);
   assign o_imem_addr     = fetch_pc;

   always_comb begin
      state_nxt    = state;
      fetch_pc_nxt = fetch_pc;
      o_imem_req   = (state == S_REQ);
      if (take_ack)
         fetch_pc_nxt = fetch_pc + STEP_C;
      if (i_redirect)
         fetch_pc_nxt = i_redirect_pc & ALIGN_MASK;
      case (state)
         S_IDLE: begin
            if (!i_redirect && (count_after_pop < DEPTH_C))
               state_nxt = S_REQ;
         end
         S_REQ: begin
            if (i_imem_ack)
               state_nxt = (!i_redirect && (count_nxt < DEPTH_C)) ? S_REQ : S_IDLE;
            else if (i_redirect)
               state_nxt = S_DROP;
         end
         S_DROP: begin
            if (i_imem_ack)
               state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state    <= S_IDLE;
         fetch_pc <= RESET_PC;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         state    <= state_nxt;
         fetch_pc <= fetch_pc_nxt;
         if (i_redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (push)
               wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
               rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_nxt;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         buf_pc[wr_ptr]    <= fetch_pc;
         buf_instr[wr_ptr] <= i_imem_data;
      end
   end

`ifndef SYNTHESIS
   ack_in_idle: assert property (@(posedge clk) disable iff (!aresetn)
      !((state == S_IDLE) && i_imem_ack))
      else $error("if_stage: imem ack with no request outstanding");
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage
module tb_if_stage;

`ifdef IF_BUF_BYPASS_EN
   localparam int LAT_EXP = 0;
`else
   localparam int LAT_EXP = 1;
`endif
   localparam int DEPTH = 2;

   logic        clk;
   logic        aresetn, i_stall, i_redirect;
   logic [31:0] i_redirect_pc;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        i_imem_ack;
   logic [31:0] i_imem_data;
   logic [31:0] o_pc;
   logic [31:0] o_instr;
   logic        o_valid;

   int          checks;
   int          errors;
   int          mem_lat;
   int          acks;
   bit          mem_busy;
   int          mem_cnt;
   logic [31:0] mem_addr;

   if_stage dut (
      .clk(clk), .aresetn(aresetn), .i_stall(i_stall), .i_redirect(i_redirect),
      .i_redirect_pc(i_redirect_pc), .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
      .i_imem_ack(i_imem_ack), .i_imem_data(i_imem_data), .o_pc(o_pc),
      .o_instr(o_instr), .o_valid(o_valid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] data_of(input logic [31:0] a);
      return 32'hC0DE_0000 ^ a;
   endfunction

   // memory: answers each request mem_lat cycles later (0 = same cycle), keeps counting through reset
   initial begin
      i_imem_ack  = 1'b0;
      i_imem_data = '0;
      acks        = 0;
      mem_busy    = 1'b0;
      mem_cnt     = 0;
      mem_addr    = '0;
      forever begin
         @(posedge clk);
         #1;
         i_imem_ack = 1'b0;
         if (mem_busy) begin
            if (mem_cnt == 0) begin
               i_imem_ack  = 1'b1;
               i_imem_data = data_of(mem_addr);
               mem_busy    = 1'b0;
               acks++;
            end else begin
               mem_cnt--;
            end
         end else if (o_imem_req && aresetn) begin
            mem_addr = o_imem_addr;
            if (mem_lat == 0) begin
               i_imem_ack  = 1'b1;
               i_imem_data = data_of(mem_addr);
               acks++;
            end else begin
               mem_busy = 1'b1;
               mem_cnt  = mem_lat - 1;
            end
         end
      end
   end

   task automatic do_reset(input int lat);
      @(posedge clk);
      #1;
      aresetn       = 1'b0;
      i_stall       = 1'b0;
      i_redirect    = 1'b0;
      i_redirect_pc = '0;
      mem_lat       = lat;
      repeat (6) @(posedge clk);
      #1 aresetn = 1'b1;
   endtask

   task automatic wait_valid(input int bound, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < bound; k++) begin
         @(negedge clk);
         if (o_valid) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_req(input int bound, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < bound; k++) begin
         @(negedge clk);
         if (o_imem_req) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      @(negedge clk);
      checks++; if (o_imem_req !== 1'b0)   begin errors++; $display("FAIL reset_req: got %b expected 0", o_imem_req); end
      checks++; if (o_imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", o_imem_addr); end
      checks++; if (o_valid !== 1'b0)      begin errors++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
      checks++; if (o_pc !== 32'h0)        begin errors++; $display("FAIL reset_pc: got %h expected 0", o_pc); end
      checks++; if (o_instr !== 32'h0)     begin errors++; $display("FAIL reset_instr: got %h expected 0", o_instr); end
   endtask

   task automatic test_stream;
      logic [31:0] exp_addr, exp_pc;
      int first_ack, first_valid;
      do_reset(0);
      exp_addr = 32'h0; exp_pc = 32'h0; first_ack = -1; first_valid = -1;
      for (int cyc = 0; cyc < 14; cyc++) begin
         @(negedge clk);
         if (o_imem_req) begin
            checks++;
            if (o_imem_addr !== exp_addr) begin errors++; $display("FAIL stream_addr cyc %0d: got %h expected %h", cyc, o_imem_addr, exp_addr); end
            if (i_imem_ack) begin
               if (first_ack < 0) first_ack = cyc;
               exp_addr += 32'd4;
            end
         end
         if (o_valid && first_valid < 0) first_valid = cyc;
         if (first_valid >= 0) begin
            checks++;
            if (o_valid !== 1'b1 || o_pc !== exp_pc || o_instr !== data_of(exp_pc)) begin
               errors++;
               $display("FAIL stream_word cyc %0d: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                        cyc, o_valid, o_pc, o_instr, exp_pc, data_of(exp_pc));
            end
            exp_pc += 32'd4;
         end
      end
      checks++;
      if (first_ack < 0 || first_valid - first_ack != LAT_EXP) begin
         errors++; $display("FAIL stream_latency: got ack cyc %0d valid cyc %0d expected latency %0d", first_ack, first_valid, LAT_EXP);
      end
   endtask

   task automatic test_stall;
      bit ok;
      int a0;
      do_reset(0);
      i_stall = 1'b1;
      a0 = acks;
      wait_valid(20, ok);
      checks++; if (!ok) begin errors++; $display("FAIL stall_first_valid: got timeout expected valid"); end
      for (int i = 0; i < 6; i++) begin
         if (i > 0) @(negedge clk);
         checks++;
         if (o_valid !== 1'b1 || o_pc !== 32'h0 || o_instr !== data_of(32'h0)) begin
            errors++; $display("FAIL stall_hold %0d: got v=%b pc=%h instr=%h expected v=1 pc=0 instr=%h", i, o_valid, o_pc, o_instr, data_of(32'h0));
         end
      end
      checks++; if (o_imem_req !== 1'b0) begin errors++; $display("FAIL stall_req_full: got %b expected 0", o_imem_req); end
      checks++; if (acks - a0 != DEPTH)  begin errors++; $display("FAIL stall_buffered: got %0d expected %0d", acks - a0, DEPTH); end
      @(posedge clk);
      #1 i_stall = 1'b0;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         checks++;
         if (o_valid !== 1'b1 || o_pc !== 32'(4 * j) || o_instr !== data_of(32'(4 * j))) begin
            errors++; $display("FAIL stall_release %0d: got v=%b pc=%h expected v=1 pc=%h", j, o_valid, o_pc, 32'(4 * j));
         end
      end
   endtask

   task automatic test_redirect_drop;
      bit ok, seen_req;
      do_reset(3);
      ok = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (o_imem_req && o_imem_addr == 32'h8) begin ok = 1'b1; break; end
      end
      checks++; if (!ok) begin errors++; $display("FAIL drop_req8: got timeout expected req of 0x8"); end
      @(posedge clk);
      #1 begin i_redirect = 1'b1; i_redirect_pc = 32'h100; end
      @(posedge clk);
      #1 i_redirect = 1'b0;
      @(negedge clk);
      checks++; if (o_imem_req !== 1'b0) begin errors++; $display("FAIL drop_req_low: got %b expected 0", o_imem_req); end
      checks++; if (o_valid !== 1'b0)    begin errors++; $display("FAIL drop_flushed: got %b expected 0", o_valid); end
      ok = 1'b0; seen_req = 1'b0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (o_imem_req && !seen_req) begin
            seen_req = 1'b1;
            checks++; if (o_imem_addr !== 32'h100) begin errors++; $display("FAIL drop_next_addr: got %h expected 100", o_imem_addr); end
         end
         if (o_valid) begin ok = 1'b1; break; end
      end
      checks++;
      if (!ok || o_pc !== 32'h100 || o_instr !== data_of(32'h100)) begin
         errors++; $display("FAIL drop_first_valid: got ok=%b pc=%h instr=%h expected pc=100 instr=%h", ok, o_pc, o_instr, data_of(32'h100));
      end
   endtask

   task automatic test_redirect_ack;
      bit ok;
      do_reset(0);
      wait_valid(20, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rack_stream: got timeout expected valid"); end
      @(posedge clk);
      #1 begin i_redirect = 1'b1; i_redirect_pc = 32'h203; end
      @(negedge clk);
      checks++; if (!(o_imem_req && i_imem_ack)) begin errors++; $display("FAIL rack_coincide: got req=%b ack=%b expected 1 1", o_imem_req, i_imem_ack); end
      @(posedge clk);
      #1 i_redirect = 1'b0;
      @(negedge clk);
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rack_empty: got %b expected 0", o_valid); end
      wait_req(10, ok);
      checks++; if (!ok || o_imem_addr !== 32'h200) begin errors++; $display("FAIL rack_next_addr: got ok=%b addr=%h expected 200", ok, o_imem_addr); end
      if (!o_valid) wait_valid(10, ok);
      checks++; if (!ok || o_pc !== 32'h200 || o_instr !== data_of(32'h200)) begin errors++; $display("FAIL rack_first_valid: got pc=%h instr=%h expected pc=200", o_pc, o_instr); end
   endtask

   task automatic test_redirect_stall_full;
      bit ok;
      do_reset(0);
      i_stall = 1'b1;
      wait_valid(20, ok);
      repeat (3) @(negedge clk);
      checks++; if (!ok || o_imem_req !== 1'b0 || o_valid !== 1'b1) begin errors++; $display("FAIL rsf_full: got req=%b valid=%b expected 0 1", o_imem_req, o_valid); end
      @(posedge clk);
      #1 begin i_redirect = 1'b1; i_redirect_pc = 32'h40; end
      @(posedge clk);
      #1 i_redirect = 1'b0;
      @(negedge clk);
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rsf_flush: got %b expected 0", o_valid); end
      wait_req(10, ok);
      checks++; if (!ok || o_imem_addr !== 32'h40) begin errors++; $display("FAIL rsf_next_addr: got ok=%b addr=%h expected 40", ok, o_imem_addr); end
      if (!o_valid) wait_valid(10, ok);
      checks++; if (!ok || o_pc !== 32'h40 || o_instr !== data_of(32'h40)) begin errors++; $display("FAIL rsf_first_valid: got pc=%h instr=%h expected pc=40", o_pc, o_instr); end
      i_stall = 1'b0;
   endtask

   task automatic test_reset_midreq;
      bit ok;
      do_reset(3);
      ok = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (o_imem_req && o_imem_addr == 32'h4) begin ok = 1'b1; break; end
      end
      checks++; if (!ok) begin errors++; $display("FAIL rmid_req4: got timeout expected req of 0x4"); end
      @(posedge clk);
      #1 aresetn = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (i_imem_ack) begin
            checks++;
            if (o_imem_req !== 1'b0 || o_imem_addr !== 32'h0 || o_valid !== 1'b0 || o_pc !== 32'h0 || o_instr !== 32'h0) begin
               errors++; $display("FAIL rmid_outputs: got req=%b addr=%h v=%b pc=%h instr=%h expected all 0",
                                  o_imem_req, o_imem_addr, o_valid, o_pc, o_instr);
            end
         end
      end
      @(posedge clk);
      #1 aresetn = 1'b1;
      wait_req(10, ok);
      checks++; if (!ok || o_imem_addr !== 32'h0) begin errors++; $display("FAIL rmid_first_addr: got ok=%b addr=%h expected 0", ok, o_imem_addr); end
      wait_valid(20, ok);
      checks++; if (!ok || o_pc !== 32'h0 || o_instr !== data_of(32'h0)) begin errors++; $display("FAIL rmid_first_word: got pc=%h instr=%h expected pc=0 instr=%h", o_pc, o_instr, data_of(32'h0)); end
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      aresetn       = 1'b0;
      i_stall       = 1'b0;
      i_redirect    = 1'b0;
      i_redirect_pc = '0;
      mem_lat       = 0;
      test_reset;
      test_stream;
      test_stall;
      test_redirect_drop;
      test_redirect_ack;
      test_redirect_stall_full;
      test_reset_midreq;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
